// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: MEM pipeline stage.
// Drives a req/ack data-memory bus for loads and stores. Raises mem_stall so
// the upstream stages freeze while an access is pending. Registers results
// into the MEM/WB pipeline register.
//
// Handshake: the request is held while dmem_req=1. The transfer completes in
// the cycle where dmem_req=1 and dmem_ack=1. Read data is valid only in that
// cycle. An ack while dmem_req=0 is ignored.
//
// Optional feature: define MEM_TIMEOUT_EN to bound the WAIT state. An access
// with no ack is force-completed on its TIMEOUT_CYCLES-th WAIT cycle. A load
// that times out returns ERR_DATA, a store that times out is dropped, and the
// sticky mem_err flag is set. Without the macro, WAIT persists until an ack
// arrives and mem_err is tied to 0.
module pipe_mem_stage #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_err,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        mem_state   // debug view of the FSM: 0=IDLE, 1=WAIT
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t state;
    state_t state_next;
    logic   access;
    logic   is_load;
    logic   forced_ack;
    logic   done;

    // When both mm2reg and mwmem are set, the access is a store.
    assign access  = mm2reg | mwmem;
    assign is_load = mm2reg & ~mwmem;

    assign dmem_we    = mwmem;
    assign dmem_addr  = malu;
    assign dmem_wdata = mb;

    // A transfer finishes on a real ack or on a timeout.
    assign done = dmem_ack | forced_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    // The 'unused' prefix marks this signal as deliberately unread.
    logic unused_cfg;
    assign unused_cfg = 1'b0;

    // The wait counter is held at zero outside WAIT, so it starts from zero
    // on every entry to WAIT. It counts WAIT cycles without an ack.
    always_ff @(posedge clock) begin
        if (!resetn || state == IDLE) begin
            wait_cnt <= '0;
        end else if (!dmem_ack && !forced_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // A real ack takes priority. The forced ack fires on the cycle in which
    // the count would reach TIMEOUT_CYCLES.
    assign forced_ack = resetn && (state == WAIT) && !dmem_ack &&
                        (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // A timeout sets the sticky error flag. Only reset clears it.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_err <= 1'b0;
        end else if (forced_ack) begin
            mem_err <= 1'b1;
        end
    end
`else
    // The 'unused' prefix marks this signal as deliberately unread. The
    // timeout parameters only matter when the timeout feature is built.
    logic [31:0] unused_cfg;
    assign unused_cfg = ERR_DATA ^ 32'(TIMEOUT_CYCLES);

    assign forced_ack = 1'b0;
    assign mem_err    = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. An access acked in its first cycle never enters WAIT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access && !done) state_next = WAIT;
            WAIT: if (done)            state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // FSM outputs. The request drops immediately when reset is asserted.
    always_comb begin
        dmem_req  = resetn & (((state == IDLE) & access) | (state == WAIT));
        mem_stall = dmem_req & ~done;
        mem_state = (state == WAIT);
    end

    // MEM/WB register. A stall inserts a bubble, and the data fields hold
    // their previous values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
            wmo    <= '0;
            walu   <= '0;
            wrn    <= '0;
        end else if (mem_stall) begin
            wwreg  <= 1'b0;
            wm2reg <= 1'b0;
        end else begin
            wwreg  <= mwreg;
            wm2reg <= mm2reg;
            walu   <= malu;
            wrn    <= mrn;
            if (dmem_req && dmem_ack && is_load) begin
                wmo <= dmem_rdata;
            end else if (forced_ack && is_load) begin
                wmo <= ERR_DATA;
            end
        end
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage.
// Runs directed vectors from a table and then random instructions. It also
// runs hand-written sequences for reset during WAIT and, when MEM_TIMEOUT_EN
// is defined, for the timeout path.
module tb_pipe_mem_stage;

    logic        clock = 1'b0;
    logic        resetn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wwreg, wm2reg, mem_state;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: MEM/WB fields as seen at the transaction level.
    logic [31:0] model_wmo, model_walu;
    logic [4:0]  model_wrn;

    typedef struct {
        logic        mwreg, mm2reg, mwmem;
        logic [31:0] alu, b;
        logic [4:0]  rn;
        int          lat;        // ack arrives this many cycles after entry
        logic [31:0] rdata;
        logic        spur;       // raise ack on a non-access instruction
        logic        exp_req, exp_we;
        int          exp_stalls;
        logic        exp_wwreg, exp_wm2reg;
        logic [31:0] exp_wmo;
    } vec_t;

    vec_t tbl[6];

    pipe_mem_stage #(.TIMEOUT_CYCLES(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clock(clock), .resetn(resetn),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .malu(malu), .mb(mb), .mrn(mrn),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_err(mem_err),
        .wwreg(wwreg), .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn),
        .mem_state(mem_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input logic wr, input logic ld, input logic st,
                                input logic [31:0] alu, input logic [31:0] b,
                                input logic [4:0] rn, input int lat,
                                input logic [31:0] rdata, input logic spur,
                                input logic [31:0] exp_wmo, input int exp_stalls);
        vec_t v;
        v.mwreg = wr; v.mm2reg = ld; v.mwmem = st;
        v.alu = alu; v.b = b; v.rn = rn; v.lat = lat; v.rdata = rdata; v.spur = spur;
        v.exp_req = ld | st; v.exp_we = st; v.exp_stalls = exp_stalls;
        v.exp_wwreg = wr; v.exp_wm2reg = ld; v.exp_wmo = exp_wmo;
        return v;
    endfunction

    // Apply one instruction and play the memory side with the given latency.
    task automatic apply(input vec_t v);
        int stop;
        stop = v.exp_req ? v.lat : 0;
        mwreg = v.mwreg; mm2reg = v.mm2reg; mwmem = v.mwmem;
        malu = v.alu; mb = v.b; mrn = v.rn;
        for (int c = 0; c <= stop; c++) begin
            dmem_ack   = v.exp_req ? (c == v.lat) : v.spur;
            dmem_rdata = (v.exp_req && c == v.lat) ? v.rdata : $urandom;
            #1;
            check("dmem_req", {31'b0, dmem_req}, {31'b0, v.exp_req});
            check("mem_stall", {31'b0, mem_stall}, {31'b0, (c < v.exp_stalls)});
            if (v.exp_req) begin
                check("dmem_we", {31'b0, dmem_we}, {31'b0, v.exp_we});
                check("dmem_addr", dmem_addr, v.alu);
                if (v.exp_we) check("dmem_wdata", dmem_wdata, v.b);
                check("mem_state", {31'b0, mem_state}, {31'b0, (c > 0)});
            end
            @(posedge clock); #1;
            if (c < v.exp_stalls) begin
                check("bubble_wwreg", {31'b0, wwreg}, 32'd0);
                check("bubble_wm2reg", {31'b0, wm2reg}, 32'd0);
                check("bubble_walu", walu, model_walu);
            end else begin
                check("wwreg", {31'b0, wwreg}, {31'b0, v.exp_wwreg});
                check("wm2reg", {31'b0, wm2reg}, {31'b0, v.exp_wm2reg});
                check("walu", walu, v.alu);
                check("wrn", {27'b0, wrn}, {27'b0, v.rn});
                check("wmo", wmo, v.exp_wmo);
                check("idle_after", {31'b0, mem_state}, 32'd0);
            end
        end
        dmem_ack = 1'b0;
        model_walu = v.alu; model_wrn = v.rn; model_wmo = v.exp_wmo;
    endtask

    initial begin
        resetn = 1'b0; mwreg = 0; mm2reg = 0; mwmem = 0;
        malu = 0; mb = 0; mrn = 0; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_wwreg", {31'b0, wwreg}, 32'd0);
        check("rst_wm2reg", {31'b0, wm2reg}, 32'd0);
        check("rst_wmo", wmo, 32'd0);
        check("rst_walu", walu, 32'd0);
        check("rst_wrn", {27'b0, wrn}, 32'd0);
        check("rst_state", {31'b0, mem_state}, 32'd0);
        check("rst_err", {31'b0, mem_err}, 32'd0);
        check("rst_req", {31'b0, dmem_req}, 32'd0);
        resetn = 1'b1;
        model_wmo = 0; model_walu = 0; model_wrn = 0;

        // Directed table.
        //             wr ld st alu           b             rn lat rdata        spur exp_wmo       stalls
        tbl[0] = mk(1, 0, 0, 32'h1234,     32'h0,        5,  0, 32'h0,        0, 32'h0,        0);
        tbl[1] = mk(1, 1, 0, 32'h40,       32'h0,        7,  0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);
        tbl[2] = mk(0, 0, 1, 32'h80,       32'h55AA,     0,  3, 32'h11111111, 0, 32'hCAFEF00D, 3);
        tbl[3] = mk(1, 0, 0, 32'h99,       32'h0,        3,  0, 32'h0,        1, 32'hCAFEF00D, 0);
        tbl[4] = mk(1, 1, 1, 32'hC0,       32'h77,       9,  1, 32'h22222222, 0, 32'hCAFEF00D, 1);
        tbl[5] = mk(1, 1, 0, 32'h100,      32'h0,        31, 2, 32'h12345678, 0, 32'h12345678, 2);
        for (int i = 0; i < 6; i++) apply(tbl[i]);

        // Random stream against the transaction-level model.
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            logic [1:0] kind;
            int lat;
            logic [31:0] rd;
            kind = 2'($urandom_range(0, 3));
            lat  = $urandom_range(0, 3);
            rd   = $urandom;
            v = mk(1'($urandom), kind == 1 || kind == 3, kind >= 2, $urandom, $urandom,
                   5'($urandom), lat, rd, 1'($urandom),
                   (kind == 1) ? rd : model_wmo, (kind != 0) ? lat : 0);
            apply(v);
        end

        // Reset while a load waits in WAIT.
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h200; mrn = 4; dmem_ack = 0;
        @(posedge clock); #1;
        check("rst_mid_wait", {31'b0, mem_state}, 32'd1);
        check("rst_mid_stall", {31'b0, mem_stall}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, dmem_req}, 32'd0);
        check("rst_mid_nostall", {31'b0, mem_stall}, 32'd0);
        @(posedge clock); #1;
        check("rst_mid_state", {31'b0, mem_state}, 32'd0);
        check("rst_mid_wwreg", {31'b0, wwreg}, 32'd0);
        check("rst_mid_wm2reg", {31'b0, wm2reg}, 32'd0);
        check("rst_mid_wmo", wmo, 32'd0);
        check("rst_mid_walu", walu, 32'd0);
        check("rst_mid_wrn", {27'b0, wrn}, 32'd0);
        resetn = 1'b1; mm2reg = 0;
        model_wmo = 0; model_walu = 0; model_wrn = 0;
        apply(mk(1, 0, 0, 32'h5, 32'h0, 2, 0, 32'h0, 0, 32'h0, 0));

`ifdef MEM_TIMEOUT_EN
        // Load that never gets an ack: force-completed on the 4th WAIT cycle.
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h300; mrn = 6; dmem_ack = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("to_stall", {31'b0, mem_stall}, {31'b0, (c < 4)});
            @(posedge clock); #1;
        end
        check("to_wmo", wmo, 32'hDEADBEEF);
        check("to_err", {31'b0, mem_err}, 32'd1);
        check("to_state", {31'b0, mem_state}, 32'd0);
        mm2reg = 0;
        @(posedge clock); #1;
        check("to_err_sticky", {31'b0, mem_err}, 32'd1);
        resetn = 1'b0;
        @(posedge clock); #1;
        check("to_err_clear", {31'b0, mem_err}, 32'd0);
        resetn = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
